alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two independent requesters (e.g. instruction executor and address/loop unit).
- Each requester submits an operation (op, A, B) over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand and op inputs, waits the ALU latency, then returns the result and flags to the winner.
- It is the only driver of the ALU inputs in the datapath.

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags,
    output logic             busy
);

    if (ALU_LAT < 1) begin : g_lat_check
        $error("alu_arbiter: ALU_LAT must be at least 1");
    end

    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          ptr_q;     // 0: req0 has priority on a tie, 1: req1
    logic          winner_q;
    logic          gnt0;
    logic          gnt1;

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt0 = req0_valid && (!req1_valid || !ptr_q);
                gnt1 = req1_valid && (!req0_valid || ptr_q);
                if (gnt0 || gnt1) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gated with rst_n so no handshake can appear while reset is held.
    assign req0_ready = gnt0 && rst_n;
    assign req1_ready = gnt1 && rst_n;
    assign rsp0_valid = (state_q == S_RESP) && !winner_q;
    assign rsp1_valid = (state_q == S_RESP) && winner_q;
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            winner_q  <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                winner_q <= gnt1;
                ptr_q    <= gnt0;
                alu_op   <= gnt1 ? req1_op : req0_op;
                alu_a    <= gnt1 ? req1_a  : req0_a;
                alu_b    <= gnt1 ? req1_b  : req0_b;
                cnt_q    <= CW'(ALU_LAT);
            end
            if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_data  <= alu_out;
                    rsp_flags <= alu_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter at ALU_LAT=1 and ALU_LAT=3
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op, alu_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
    logic [3:0] alu_flags, rsp_flags;
    logic       rsp0_valid, rsp1_valid, busy;

    logic       l3_req0_valid, l3_req1_valid, l3_req0_ready, l3_req1_ready;
    logic [2:0] l3_req0_op, l3_req1_op, l3_alu_op;
    logic [7:0] l3_req0_a, l3_req0_b, l3_req1_a, l3_req1_b, l3_alu_a, l3_alu_b, l3_alu_out, l3_rsp_data;
    logic [3:0] l3_alu_flags, l3_rsp_flags;
    logic       l3_rsp0_valid, l3_rsp1_valid, l3_busy;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return ~a;
            3'd5:    return (a == b) ? 8'h01 : 8'h00;
            3'd6:    return a >> 1;
            default: return a << 1;
        endcase
    endfunction

    assign alu_out      = alu_f(alu_op, alu_a, alu_b);
    assign l3_alu_out   = alu_f(l3_alu_op, l3_alu_a, l3_alu_b);
    assign l3_alu_flags = 4'h0;

    alu_arbiter #(.WIDTH(8), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_flags(alu_flags),
        .busy(busy)
    );

    alu_arbiter #(.WIDTH(8), .ALU_LAT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_op(l3_req0_op), .req0_a(l3_req0_a), .req0_b(l3_req0_b),
        .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_op(l3_req1_op), .req1_a(l3_req1_a), .req1_b(l3_req1_b),
        .rsp0_valid(l3_rsp0_valid), .rsp1_valid(l3_rsp1_valid), .rsp_data(l3_rsp_data), .rsp_flags(l3_rsp_flags),
        .alu_op(l3_alu_op), .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_out(l3_alu_out), .alu_flags(l3_alu_flags),
        .busy(l3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req0_ready && req0_valid) begin
                e = '{id: 1'b0, data: alu_f(req0_op, req0_a, req0_b)};
                sb.push_back(e);
            end
            if (req1_ready && req1_valid) begin
                e = '{id: 1'b1, data: alu_f(req1_op, req1_a, req1_b)};
                sb.push_back(e);
            end
            chk("ready_exclusive", 32'(req0_ready & req1_ready), 0);
            chk("ready_only_idle", 32'((req0_ready | req1_ready) & busy), 0);
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
                chk("rsp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        alu_flags = 4'h0;
        l3_req0_valid = 0; l3_req0_op = 0; l3_req0_a = 0; l3_req0_b = 0;
        l3_req1_valid = 0; l3_req1_op = 0; l3_req1_a = 0; l3_req1_b = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        rst_n = 1;

        // req0 alone: add 0x03 + 0x11
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'h03; req0_b = 8'h11;
        @(negedge clk);
        chk("t1_ready0_c0", 32'(req0_ready), 1);
        chk("t1_ready1_c0", 32'(req1_ready), 0);
        chk("t1_busy_c0", 32'(busy), 0);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_alu_op_c1", 32'(alu_op), 0);
        chk("t1_alu_a_c1", 32'(alu_a), 32'h03);
        chk("t1_alu_b_c1", 32'(alu_b), 32'h11);
        chk("t1_rsp0_c1", 32'(rsp0_valid), 0);
        @(posedge clk); @(negedge clk);
        chk("t1_rsp0_c2", 32'(rsp0_valid), 1);
        chk("t1_rsp1_c2", 32'(rsp1_valid), 0);
        chk("t1_data_c2", 32'(rsp_data), 32'h14);
        @(posedge clk); @(negedge clk);
        chk("t1_rsp0_c3", 32'(rsp0_valid), 0);
        chk("t1_busy_c3", 32'(busy), 0);
        chk("t1_alu_a_hold", 32'(alu_a), 32'h03);
        chk("t1_data_hold", 32'(rsp_data), 32'h14);

        // Reset during WAIT drops the op
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'd6; req0_a = 8'h40; req0_b = 8'h00;
        @(negedge clk);
        chk("t5_ready0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1; req1_op = 3'd2; req1_a = 8'hF0; req1_b = 8'h0F;
        #1;
        rst_n = 0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_alu_op", 32'(alu_op), 0);
        chk("t5_alu_a", 32'(alu_a), 0);
        chk("t5_alu_b", 32'(alu_b), 0);
        chk("t5_rsp_data", 32'(rsp_data), 0);
        chk("t5_rsp_flags", 32'(rsp_flags), 0);
        chk("t5_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        chk("t5_ready", 32'({req0_ready, req1_ready}), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // Both valid continuously: grants alternate starting with req0
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("t2_ready0_c%0d", k), 32'(req0_ready), 32'(k % 6 == 0));
            chk($sformatf("t2_ready1_c%0d", k), 32'(req1_ready), 32'(k % 6 == 3));
            chk($sformatf("t2_rsp0_c%0d", k), 32'(rsp0_valid), 32'(k % 6 == 2));
            chk($sformatf("t2_rsp1_c%0d", k), 32'(rsp1_valid), 32'(k % 6 == 5));
            @(posedge clk); #1;
            if (k == 11) begin
                req0_valid = 0;
                req1_valid = 0;
            end
        end

        // req1 alone with pointer at req0; flags captured at the capture edge only
        req1_valid = 1; req1_op = 3'd1; req1_a = 8'h05; req1_b = 8'h05;
        alu_flags = 4'hA;
        @(negedge clk);
        chk("t6_ready1", 32'(req1_ready), 1);
        chk("t6_ready0", 32'(req0_ready), 0);
        @(posedge clk); #1;
        req1_valid = 0;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 1);
        @(posedge clk); #1;
        alu_flags = 4'h5;
        @(negedge clk);
        chk("t3_rsp1", 32'(rsp1_valid), 1);
        chk("t3_data", 32'(rsp_data), 0);
        chk("t3_flags", 32'(rsp_flags), 32'hA);
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("t3_flags_hold", 32'(rsp_flags), 32'hA);
        chk("t6_tie_ready0", 32'(req0_ready), 1);
        chk("t6_tie_ready1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge clk);
        #1;

        // ALU_LAT=3: shl 0x81, inputs disturbed during WAIT
        l3_req0_valid = 1; l3_req0_op = 3'd7; l3_req0_a = 8'h81; l3_req0_b = 8'h00;
        @(negedge clk);
        chk("t4_ready0_c0", 32'(l3_req0_ready), 1);
        chk("t4_busy_c0", 32'(l3_busy), 0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                l3_req0_valid = 0; l3_req0_op = 3'd0; l3_req0_a = 8'h55; l3_req0_b = 8'h66;
            end
            @(negedge clk);
            chk($sformatf("t4_busy_c%0d", c), 32'(l3_busy), 32'(c <= 4));
            chk($sformatf("t4_rsp0_c%0d", c), 32'(l3_rsp0_valid), 32'(c == 4));
            chk($sformatf("t4_rsp1_c%0d", c), 32'(l3_rsp1_valid), 0);
            if (c <= 4) begin
                chk($sformatf("t4_alu_op_c%0d", c), 32'(l3_alu_op), 32'd7);
                chk($sformatf("t4_alu_a_c%0d", c), 32'(l3_alu_a), 32'h81);
            end
            if (c == 4) begin
                chk("t4_data", 32'(l3_rsp_data), 32'h02);
            end
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
